// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer and data memory: access-type
// encodings, store-entry layout and the default word-index bit range.
package store_buffer_pkg;

   typedef enum logic [1:0] {
      MT_NONE = 2'b00,
      MT_BYTE = 2'b01,
      MT_HALF = 2'b10,
      MT_WORD = 2'b11
   } mtype_e;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int PC_W       = 32;
   localparam int IDX_HI_DEF = 13;
   localparam int IDX_LO_DEF = 2;

   typedef struct packed {
      mtype_e              typ;
      logic [ADDR_W-1:0]   addr;
      logic [DATA_W-1:0]   data;
      logic [PC_W-1:0]     pc;
   } st_entry_t;

endpackage

// File: rtl/stbuf_match.sv
// Per-entry word-index comparator array. Produces one hit bit per valid
// entry whose word index equals the load's word index (type is ignored).
module stbuf_match
   import store_buffer_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int IDX_HI = IDX_HI_DEF,
   parameter int IDX_LO = IDX_LO_DEF
) (
   input  logic [DEPTH-1:0][ADDR_W-1:0] i_ent_addr,
   input  logic [DEPTH-1:0]             i_ent_vld,
   input  logic [ADDR_W-1:0]            i_ld_addr,
   output logic [DEPTH-1:0]             o_hit
);

   // Bits outside the word index take no part in the compare.
   logic w_unused;
   assign w_unused = ^{i_ent_addr, i_ld_addr};

   for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
      assign o_hit[g] = i_ent_vld[g] &&
                        (i_ent_addr[g][IDX_HI:IDX_LO] == i_ld_addr[IDX_HI:IDX_LO]);
   end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between MEM and a single-port data memory.
// Stores drain one per cycle whenever no load owns the port; loads that hit
// a pending store word raise ld_hazard.
// Optional build macro STBUF_BYPASS_EN: a store arriving while the buffer is
// empty and the port is free is written straight through in the same cycle.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int PTR_W  = 2,
   parameter int IDX_HI = IDX_HI_DEF,
   parameter int IDX_LO = IDX_LO_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [1:0]        st_type,
   input  logic [31:0]       st_addr,
   input  logic [31:0]       st_data,
   input  logic [31:0]       st_pc,
   input  logic              ld_valid,
   input  logic [31:0]       ld_addr,
   output logic              ld_hazard,
   output logic              dm_we,
   output logic [1:0]        dm_type,
   output logic [31:0]       dm_addr,
   output logic [31:0]       dm_din,
   output logic [31:0]       dm_pc,
   output logic              empty,
   output logic [PTR_W:0]    count
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   st_entry_t                     r_ent [DEPTH];
   logic [DEPTH-1:0]              r_vld;
   logic [PTR_W-1:0]              r_wptr;
   logic [PTR_W-1:0]              r_rptr;
   logic [PTR_W:0]                r_count;

   st_entry_t                     w_in;
   st_entry_t                     w_head;
   st_entry_t                     w_out;
   logic                          w_empty;
   logic                          w_push;
   logic                          w_pop;
   logic                          w_byp;
   logic                          w_enq;
   logic [DEPTH-1:0][ADDR_W-1:0]  w_ent_addr;
   logic [DEPTH-1:0]              w_hit;

   assign w_in.typ  = mtype_e'(st_type);
   assign w_in.addr = st_addr;
   assign w_in.data = st_data;
   assign w_in.pc   = st_pc;
   assign w_head    = r_ent[r_rptr];

   // Ready depends only on registered occupancy, so a same-cycle pop never
   // lets a store into a full buffer.
   assign w_empty  = (r_count == '0);
   assign st_ready = (r_count != FULL_CNT);
   assign w_push   = st_valid & st_ready & (st_type != MT_NONE);
   assign w_pop    = ~w_empty & ~ld_valid;

`ifdef STBUF_BYPASS_EN
   assign w_byp = w_empty & ~ld_valid & w_push;
`else
   assign w_byp = 1'b0;
`endif

   assign w_enq = w_push & ~w_byp;

   // Memory-side outputs: head entry on a drain, incoming store on bypass,
   // otherwise all zero.
   always_comb begin
      w_out = '0;
      if (w_pop)
         w_out = w_head;
      else if (w_byp)
         w_out = w_in;
   end

   assign dm_we   = w_pop | w_byp;
   assign dm_type = w_out.typ;
   assign dm_addr = w_out.addr;
   assign dm_din  = w_out.data;
   assign dm_pc   = w_out.pc;
   assign empty   = w_empty;
   assign count   = r_count;

   for (genvar g = 0; g < DEPTH; g++) begin : g_addr
      assign w_ent_addr[g] = r_ent[g].addr;
   end

   stbuf_match #(
      .DEPTH  (DEPTH),
      .IDX_HI (IDX_HI),
      .IDX_LO (IDX_LO)
   ) u_match (
      .i_ent_addr (w_ent_addr),
      .i_ent_vld  (r_vld),
      .i_ld_addr  (ld_addr),
      .o_hit      (w_hit)
   );

   assign ld_hazard = ld_valid & (|w_hit);

   // FIFO state: enqueue at tail, retire head, track occupancy. Payloads
   // are not cleared on reset; the valid bits gate them.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_vld   <= '0;
      end else begin
         if (w_enq) begin
            r_ent[r_wptr] <= w_in;
            r_vld[r_wptr] <= 1'b1;
            r_wptr        <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_vld[r_rptr] <= 1'b0;
            r_rptr        <= r_rptr + 1'b1;
         end
         r_count <= r_count + (PTR_W+1)'(w_enq) - (PTR_W+1)'(w_pop);
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a queue model.
module tb_store_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        st_valid;
   logic        st_ready;
   logic [1:0]  st_type;
   logic [31:0] st_addr, st_data, st_pc;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic        ld_hazard;
   logic        dm_we;
   logic [1:0]  dm_type;
   logic [31:0] dm_addr, dm_din, dm_pc;
   logic        empty;
   logic [2:0]  count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   store_buffer dut (
      .clk(clk), .reset(reset),
      .st_valid(st_valid), .st_ready(st_ready), .st_type(st_type),
      .st_addr(st_addr), .st_data(st_data), .st_pc(st_pc),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
      .dm_we(dm_we), .dm_type(dm_type), .dm_addr(dm_addr),
      .dm_din(dm_din), .dm_pc(dm_pc), .empty(empty), .count(count)
   );

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic sv, input logic [1:0] ty, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] p,
                        input logic lv, input logic [31:0] la);
      st_valid = sv; st_type = ty; st_addr = a; st_data = d; st_pc = p;
      ld_valid = lv; ld_addr = la;
   endtask

   typedef struct {
      logic        sv;
      logic [1:0]  st;
      logic [31:0] sa, sd;
      logic        lv;
      logic [31:0] la;
      logic        we;
      logic [1:0]  ty;
      logic [31:0] da, dd;
      logic [2:0]  cnt;
      logic        rdy, hz, emp;
   } vec_t;

   vec_t vt [19];

   typedef struct {
      logic [1:0]  t;
      logic [31:0] a, d, p;
   } ent_t;

   ent_t q[$];

   // Single store on an idle buffer: one cycle of latency, or none with bypass.
   task automatic seq_single(input logic [1:0] ty, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] p);
      drive(1, ty, a, d, p, 0, 0);
      #1;
`ifdef STBUF_BYPASS_EN
      chk("single_byp_we", dm_we, 1);
      chk("single_byp_addr", dm_addr, a);
      chk("single_byp_din", dm_din, d);
      chk("single_byp_type", dm_type, ty);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("single_byp_cnt", count, 0);
      chk("single_byp_we_after", dm_we, 0);
`else
      chk("single_we_early", dm_we, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("single_we", dm_we, 1);
      chk("single_addr", dm_addr, a);
      chk("single_din", dm_din, d);
      chk("single_type", dm_type, ty);
      chk("single_pc", dm_pc, p);
      chk("single_cnt", count, 1);
`endif
      tick();
      chk("single_empty_after", empty, 1);
   endtask

   initial begin
      vt[0]  = '{1, 2'b11, 32'h00, 32'h11, 1, 32'h40,   0, 2'd0, 32'h0,  32'h0,  3'd0, 1, 0, 1};
      vt[1]  = '{1, 2'b11, 32'h04, 32'h22, 1, 32'h40,   0, 2'd0, 32'h0,  32'h0,  3'd1, 1, 0, 0};
      vt[2]  = '{1, 2'b11, 32'h08, 32'h33, 1, 32'h40,   0, 2'd0, 32'h0,  32'h0,  3'd2, 1, 0, 0};
      vt[3]  = '{1, 2'b11, 32'h0C, 32'h44, 1, 32'h40,   0, 2'd0, 32'h0,  32'h0,  3'd3, 1, 0, 0};
      vt[4]  = '{1, 2'b11, 32'h10, 32'h55, 1, 32'h40,   0, 2'd0, 32'h0,  32'h0,  3'd4, 0, 0, 0};
      vt[5]  = '{0, 2'b00, 32'h00, 32'h00, 1, 32'h08,   0, 2'd0, 32'h0,  32'h0,  3'd4, 0, 1, 0};
      vt[6]  = '{0, 2'b00, 32'h00, 32'h00, 0, 32'h00,   1, 2'd3, 32'h00, 32'h11, 3'd4, 0, 0, 0};
      vt[7]  = '{0, 2'b00, 32'h00, 32'h00, 0, 32'h00,   1, 2'd3, 32'h04, 32'h22, 3'd3, 1, 0, 0};
      vt[8]  = '{0, 2'b00, 32'h00, 32'h00, 0, 32'h00,   1, 2'd3, 32'h08, 32'h33, 3'd2, 1, 0, 0};
      vt[9]  = '{0, 2'b00, 32'h00, 32'h00, 0, 32'h00,   1, 2'd3, 32'h0C, 32'h44, 3'd1, 1, 0, 0};
      vt[10] = '{0, 2'b00, 32'h00, 32'h00, 0, 32'h00,   0, 2'd0, 32'h0,  32'h0,  3'd0, 1, 0, 1};
      vt[11] = '{1, 2'b01, 32'h21, 32'hAB, 1, 32'h100,  0, 2'd0, 32'h0,  32'h0,  3'd0, 1, 0, 1};
      vt[12] = '{0, 2'b00, 32'h00, 32'h00, 1, 32'h23,   0, 2'd0, 32'h0,  32'h0,  3'd1, 1, 1, 0};
      vt[13] = '{0, 2'b00, 32'h00, 32'h00, 1, 32'h24,   0, 2'd0, 32'h0,  32'h0,  3'd1, 1, 0, 0};
      vt[14] = '{0, 2'b00, 32'h00, 32'h00, 1, 32'h4021, 0, 2'd0, 32'h0,  32'h0,  3'd1, 1, 1, 0};
      vt[15] = '{0, 2'b00, 32'h00, 32'h00, 0, 32'h00,   1, 2'd1, 32'h21, 32'hAB, 3'd1, 1, 0, 0};
      vt[16] = '{0, 2'b00, 32'h00, 32'h00, 0, 32'h00,   0, 2'd0, 32'h0,  32'h0,  3'd0, 1, 0, 1};
      vt[17] = '{1, 2'b00, 32'h50, 32'h77, 0, 32'h00,   0, 2'd0, 32'h0,  32'h0,  3'd0, 1, 0, 1};
      vt[18] = '{0, 2'b00, 32'h00, 32'h00, 0, 32'h00,   0, 2'd0, 32'h0,  32'h0,  3'd0, 1, 0, 1};

      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      chk("rst_empty", empty, 1);
      chk("rst_ready", st_ready, 1);
      chk("rst_we", dm_we, 0);
      chk("rst_hazard", ld_hazard, 0);
      chk("rst_count", count, 0);
      reset = 1'b0;

      // Directed vector table
      for (int i = 0; i < 19; i++) begin
         drive(vt[i].sv, vt[i].st, vt[i].sa, vt[i].sd, 32'h1000 + i, vt[i].lv, vt[i].la);
         #1;
         chk($sformatf("vec%0d_we", i), dm_we, vt[i].we);
         chk($sformatf("vec%0d_type", i), dm_type, vt[i].ty);
         chk($sformatf("vec%0d_addr", i), dm_addr, vt[i].da);
         chk($sformatf("vec%0d_din", i), dm_din, vt[i].dd);
         chk($sformatf("vec%0d_count", i), count, vt[i].cnt);
         chk($sformatf("vec%0d_ready", i), st_ready, vt[i].rdy);
         chk($sformatf("vec%0d_hazard", i), ld_hazard, vt[i].hz);
         chk($sformatf("vec%0d_empty", i), empty, vt[i].emp);
         tick();
      end

      // Single stores, idle buffer
      seq_single(2'b11, 32'h10, 32'hDEADBEEF, 32'h3000);
      seq_single(2'b10, 32'h08, 32'h1234, 32'h3004);

      // Full buffer: push refused while popping, then push+pop at count 3 across wrap
      for (int i = 0; i < 4; i++) begin
         drive(1, 2'b11, 32'h100 + 4*i, 32'hA0 + i, 32'h2000 + i, 1, 32'h40);
         tick();
      end
      drive(1, 2'b11, 32'h200, 32'hA9, 32'h2009, 0, 0);
      #1;
      chk("full_ready", st_ready, 0);
      chk("full_pop_din", dm_din, 32'hA0);
      chk("full_count", count, 4);
      tick();
      drive(1, 2'b11, 32'h110, 32'hA4, 32'h2004, 0, 0);
      #1;
      chk("pp_count_before", count, 3);
      chk("pp_ready", st_ready, 1);
      chk("pp_din", dm_din, 32'hA1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("pp_count_after", count, 3);
      for (int i = 2; i < 5; i++) begin
         chk($sformatf("wrap_din%0d", i), dm_din, 32'hA0 + i);
         chk($sformatf("wrap_we%0d", i), dm_we, 1);
         tick();
      end
      chk("wrap_empty", empty, 1);
      chk("wrap_we_idle", dm_we, 0);

      // Reset with two pending stores and a push in the same cycle
      for (int i = 0; i < 2; i++) begin
         drive(1, 2'b11, 32'h300 + 4*i, 32'hC0 + i, 32'h4000 + i, 1, 32'h40);
         tick();
      end
      reset = 1'b1;
      drive(1, 2'b11, 32'h308, 32'hC2, 32'h4002, 1, 32'h40);
      #1;
      chk("prerst_count", count, 2);
      tick();
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("midrst_count", count, 0);
      chk("midrst_empty", empty, 1);
      chk("midrst_we", dm_we, 0);
      tick();
      chk("midrst_we2", dm_we, 0);

      // Randomized traffic against the queue model
      q.delete();
      for (int c = 0; c < 600; c++) begin
         logic        m_ready, m_push, m_byp, m_pop, m_hz, e_we;
         logic [1:0]  e_ty;
         logic [31:0] e_a, e_d, e_p;
         ent_t        e;
         reset = ($urandom_range(0, 80) == 0);
         drive($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
               $urandom & 32'h0000_C03F, $urandom, $urandom,
               $urandom_range(0, 2) == 0, $urandom & 32'h0000_C03F);
         #1;
         m_ready = (q.size() < 4);
         m_push  = st_valid && m_ready && (st_type != 2'b00);
         m_pop   = (q.size() > 0) && !ld_valid;
`ifdef STBUF_BYPASS_EN
         m_byp   = (q.size() == 0) && !ld_valid && m_push;
`else
         m_byp   = 1'b0;
`endif
         e_we = m_pop || m_byp;
         e_ty = 0; e_a = 0; e_d = 0; e_p = 0;
         if (m_pop) begin
            e_ty = q[0].t; e_a = q[0].a; e_d = q[0].d; e_p = q[0].p;
         end else if (m_byp) begin
            e_ty = st_type; e_a = st_addr; e_d = st_data; e_p = st_pc;
         end
         m_hz = 1'b0;
         foreach (q[k])
            if (((q[k].a ^ ld_addr) & 32'h0000_3FFC) == 0) m_hz = 1'b1;
         m_hz = m_hz && ld_valid;
         chk("rnd_ready", st_ready, m_ready);
         chk("rnd_count", count, q.size());
         chk("rnd_empty", empty, q.size() == 0);
         chk("rnd_hazard", ld_hazard, m_hz);
         chk("rnd_we", dm_we, e_we);
         chk("rnd_type", dm_type, e_ty);
         chk("rnd_addr", dm_addr, e_a);
         chk("rnd_din", dm_din, e_d);
         chk("rnd_pc", dm_pc, e_p);
         if (reset) begin
            q.delete();
         end else begin
            if (m_pop) void'(q.pop_front());
            if (m_push && !m_byp) begin
               e.t = st_type; e.a = st_addr; e.d = st_data; e.p = st_pc;
               q.push_back(e);
            end
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- FIFO store buffer between the MEM pipeline stage and the single-port data memory.
- Decouples stores from the memory port: stores are queued and drained one per cycle, in order, whenever the port is not taken by a load.
- Loads have priority on the port. A load whose word address matches any pending store raises a hazard (stall) until that store has drained.
- Output side drives the data memory's write strobe, access type, address, data and PC trace fields directly.

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- PTR_W, 2, log2(DEPTH).
- IDX_HI, 13, top address bit of the word index used for hazard compare.
- IDX_LO, 2, bottom address bit of the word index.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- st_valid  in  1  MEM stage presents a store
- st_ready  out  1  buffer can accept a store this cycle
- st_type  in  2  00 none, 01 byte, 10 half, 11 word
- st_addr  in  32  byte address
- st_data  in  32  store data, unaligned (low bits)
- st_pc  in  32  PC of the store, for trace
- ld_valid  in  1  MEM stage presents a load (owns the memory port this cycle)
- ld_addr  in  32  load byte address
- ld_hazard  out  1  load overlaps a pending store; pipeline must stall
- dm_we  out  1  memory write strobe
- dm_type  out  2  access type to memory
- dm_addr  out  32  address to memory when dm_we=1
- dm_din  out  32  data to memory
- dm_pc  out  32  trace PC to memory
- empty  out  1  no pending stores
- count  out  PTR_W+1  number of occupied entries

Behaviour:
- Reset (synchronous, clk rising, reset=1):
  - Read and write pointers and count go to 0; all entry valid bits are cleared.
  - Outputs: empty=1, st_ready=1, dm_we=0, ld_hazard=0.
  - Entry payloads need not be cleared.
  - Reset dominates every other input in that cycle, including a simultaneous push.
- Enqueue: push = st_valid & st_ready & (st_type != 00). The entry {type, addr, data, pc} is written at the write pointer on the clock edge. st_type = 00 is ignored, with no state change.
- st_ready = (count != DEPTH). This is combinational from registered count only and never depends on st_valid.
- Drain: pop = !empty & !ld_valid.
  - Outputs are combinational from the head entry: dm_we=pop, and dm_type/dm_addr/dm_din/dm_pc from the head.
  - The head advances on the same edge the memory performs the write.
  - Latency: a store pushed at edge N is at the head no earlier than cycle N+1, and is written to memory at edge N+1 at the earliest.
- When dm_we=0: dm_type=00 and dm_addr/dm_din/dm_pc=0.
- Simultaneous push and pop: count unchanged. This is legal when full, because st_ready is derived from the registered count, so no push is accepted when full even if a pop occurs.
- Full: st_ready=0, the store is held in MEM, and the pipeline stalls upstream.
- Empty: dm_we=0, ld_hazard=0.
- Hazard:
  - ld_hazard = ld_valid & OR over valid entries of (entry.addr[IDX_HI:IDX_LO] == ld_addr[IDX_HI:IDX_LO]). This is a word-granular compare regardless of type.
  - While ld_hazard=1 and ld_valid is held, nothing drains. The pipeline must drop ld_valid for the stall: the stage asserts the stall, deasserts ld_valid until hazard-free, then retries.
- Pointer wrap: the pointers are PTR_W bits and wrap modulo DEPTH. count is PTR_W+1 bits so full and empty are distinguished.
- Ordering: strictly FIFO, with no coalescing and no reordering.
- Reset mid-drain: the pending stores are discarded, and the memory contents already written remain.

Optional Feature:
- Macro STBUF_BYPASS_EN.
- When defined: if empty=1, ld_valid=0 and push=1, the store is driven straight to the dm_* outputs in the same cycle (dm_we=1) and is not enqueued. count stays 0.
- When undefined: every store passes through the FIFO (minimum 1 cycle of latency).
- Hazard logic is unaffected, because a bypassed store is never pending.

Decomposition:
- Shared package/header: M_type encodings (MT_NONE=00, MT_BYTE=01, MT_HALF=10, MT_WORD=11), the store-entry field widths, and the IDX_HI/IDX_LO defaults. This keeps the memory and the buffer in agreement on word indexing.
- One natural sub-module: stbuf_match, a combinational per-entry word-index comparator array producing the hit vector that is reduced to ld_hazard.
- Everything else stays in the top module.

Test Plan:
- Reset, then push word 0xDEADBEEF @0x10 (pc 0x3000) with ld_valid=0 -> next cycle dm_we=1, dm_addr=0x10, dm_din=0xDEADBEEF, dm_type=11. empty=1 after the edge.
- Hold ld_valid=1 (addr 0x40); push 4 stores @0x00/0x04/0x08/0x0C -> count=4, st_ready=0, 5th store not accepted. Drop ld_valid -> drains in order over 4 cycles; count returns to 0.
- Store byte 0xAB @0x21, then load @0x23 -> ld_hazard=1 (same word index 8). Load @0x24 -> ld_hazard=0.
- Full buffer with push and pop in the same cycle -> push refused (st_ready=0), count 4->3. With count=3, push+pop -> count stays 3; pointer wraps past entry 3 correctly.
- Reset asserted while count=2 with a push in the same cycle -> next cycle count=0, empty=1, dm_we=0; no memory write occurs for the discarded stores.
- STBUF_BYPASS_EN defined, buffer empty, push half 0x1234 @0x8 -> dm_we=1 in the same cycle, count stays 0. Undefined -> dm_we=1 one cycle later.
